// File: rtl/rv32_pipe_pkg.sv
// Shared ID/EX pipeline definitions: rb field layout, NOP encodings and
// hazard-controller state encoding.
package rv32_pipe_pkg;

    localparam int RB_W      = 19;
    localparam int S1_MSB    = 18;
    localparam int S1_LSB    = 14;
    localparam int S2_MSB    = 13;
    localparam int S2_LSB    = 9;
    localparam int D1_MSB    = 8;
    localparam int D1_LSB    = 4;
    localparam int LOAD_BIT  = 3;
    localparam int STORE_BIT = 2;
    localparam int SRC_MSB   = 1;
    localparam int SRC_LSB   = 0;

    typedef logic [RB_W-1:0] rb_t;
    typedef logic [4:0]      reg_idx_t;

    localparam rb_t         RB_NOP   = 19'd0;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [1:0] ST_RUN_ENC      = 2'd0;
    localparam logic [1:0] ST_BUBBLE_ENC   = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT_ENC = 2'd2;
    localparam logic [1:0] ST_FLUSH_ENC    = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = ST_RUN_ENC,
        ST_BUBBLE   = ST_BUBBLE_ENC,
        ST_MEM_WAIT = ST_MEM_WAIT_ENC,
        ST_FLUSH    = ST_FLUSH_ENC
    } hz_state_e;

    function automatic reg_idx_t rb_s1(input rb_t rb);
        return rb[S1_MSB:S1_LSB];
    endfunction

    function automatic reg_idx_t rb_s2(input rb_t rb);
        return rb[S2_MSB:S2_LSB];
    endfunction

    function automatic reg_idx_t rb_d1(input rb_t rb);
        return rb[D1_MSB:D1_LSB];
    endfunction

    // A slot produces a register result only with a nonzero destination and no store.
    function automatic logic rb_writes(input rb_t rb);
        return (rb_d1(rb) != 5'd0) && !rb[STORE_BIT];
    endfunction

endpackage

// File: rtl/rv32_rb_shadow.sv
// Two-slot shadow of the ID/EX queue register-bank stages; flags when a
// decode source register is the destination of a load still in flight.
module rv32_rb_shadow
    import rv32_pipe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  rb_t  id_rb,
    input  logic flush,
    input  logic busy,
    output logic load_hit
);

    rb_t slot0;
    rb_t slot1;

    function automatic logic load_dest_is(input rb_t slot, input reg_idx_t src);
        return (src != 5'd0) && slot[LOAD_BIT] && rb_writes(slot) && (rb_d1(slot) == src);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0 <= RB_NOP;
            slot1 <= RB_NOP;
        end else begin
            if (flush) begin
                slot0 <= RB_NOP;
            end else if (!busy) begin
                slot0 <= id_rb;
            end
            // NOTE: non-blocking, so slot1 takes slot0's value from before this edge.
            slot1 <= slot0;
        end
    end

    assign load_hit = load_dest_is(slot0, rb_s1(id_rb)) || load_dest_is(slot0, rb_s2(id_rb))
                   || load_dest_is(slot1, rb_s1(id_rb)) || load_dest_is(slot1, rb_s2(id_rb));

endmodule

// File: rtl/rv32_hazard_ctrl.sv
// ID/EX queue control: load-use bubbles, memory-wait holds and redirect
// flush windows, plus a saturating stall-cycle counter.
module rv32_hazard_ctrl
    import rv32_pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  rb_t              id_rb,
    input  logic             id_valid,
    input  logic             ex_mem_wait,
    input  logic             ex_redirect,
    output logic             flush,
    output logic             busy,
    output logic             id_hold,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    hz_state_e       state;
    hz_state_e       state_nx;
    logic [FC_W-1:0] flush_cnt;
    logic [FC_W-1:0] flush_cnt_nx;
    logic            load_hit;
    logic            load_use;

    rv32_rb_shadow u_shadow (
        .clk      (clk),
        .rst      (rst),
        .id_rb    (id_rb),
        .flush    (flush),
        .busy     (busy),
        .load_hit (load_hit)
    );

    assign load_use = id_valid && load_hit;

    // flush_cnt counts flush cycles still owed after the current one.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        flush        = 1'b0;
        busy         = 1'b0;
        id_hold      = 1'b0;
        state_nx     = ST_RUN;
        flush_cnt_nx = flush_cnt;
        if (rst) begin
            flush   = 1'b1;
            id_hold = 1'b1;
        end else if (ex_redirect) begin
            flush        = 1'b1;
            flush_cnt_nx = FLUSH_LOAD;
            state_nx     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (state == ST_FLUSH) begin
            flush        = 1'b1;
            flush_cnt_nx = flush_cnt - FC_W'(1);
            state_nx     = (flush_cnt_nx != '0) ? ST_FLUSH : ST_RUN;
        end else if (ex_mem_wait) begin
            busy     = 1'b1;
            id_hold  = 1'b1;
            state_nx = ST_MEM_WAIT;
        end else if (load_use) begin
            flush    = 1'b1;
            id_hold  = 1'b1;
            state_nx = ST_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nx;
            flush_cnt <= flush_cnt_nx;
            if ((busy || id_hold) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Directed bench for rv32_hazard_ctrl: reset, load-use distances, memory
// wait, redirect windows, priority, mid-operation reset and counter saturation.
module tb_rv32_hazard_ctrl;
    import rv32_pipe_pkg::*;

    localparam logic [2:0] O_RUN = 3'b000;   // {flush, busy, id_hold}
    localparam logic [2:0] O_BUB = 3'b101;
    localparam logic [2:0] O_MEM = 3'b011;
    localparam logic [2:0] O_FL  = 3'b100;
    localparam logic [2:0] O_RST = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    rb_t         id_rb;
    logic        id_valid;
    logic        ex_mem_wait;
    logic        ex_redirect;
    logic        flush, busy, id_hold;
    logic [31:0] stall_cnt;
    logic        flush_s, busy_s, id_hold_s;
    logic [3:0]  stall_cnt_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv32_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rb       (id_rb),
        .id_valid    (id_valid),
        .ex_mem_wait (ex_mem_wait),
        .ex_redirect (ex_redirect),
        .flush       (flush),
        .busy        (busy),
        .id_hold     (id_hold),
        .stall_cnt   (stall_cnt)
    );

    rv32_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .id_rb       (id_rb),
        .id_valid    (id_valid),
        .ex_mem_wait (ex_mem_wait),
        .ex_redirect (ex_redirect),
        .flush       (flush_s),
        .busy        (busy_s),
        .id_hold     (id_hold_s),
        .stall_cnt   (stall_cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs are set at posedge+1; outputs are sampled mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [2:0] fbh);
        #3;
        check(tag, {29'd0, flush, busy, id_hold}, {29'd0, fbh});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_valid    = 1'b0;
        id_rb       = RB_NOP;
        ex_mem_wait = 1'b0;
        ex_redirect = 1'b0;
    endtask

    function automatic rb_t mk(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d1,
                               input logic ld, input logic st);
        return {s1, s2, d1, ld, st, 2'b00};
    endfunction

    rb_t lw5, add5, xor_op, sub5, lw0, use0, mem_op;

    initial begin
        lw5    = mk(5'd2,  5'd0,  5'd5,  1'b1, 1'b0);
        add5   = mk(5'd5,  5'd6,  5'd7,  1'b0, 1'b0);
        xor_op = mk(5'd9,  5'd10, 5'd8,  1'b0, 1'b0);
        sub5   = mk(5'd11, 5'd5,  5'd12, 1'b0, 1'b0);
        lw0    = mk(5'd2,  5'd0,  5'd0,  1'b1, 1'b0);
        use0   = mk(5'd0,  5'd0,  5'd13, 1'b0, 1'b0);
        mem_op = mk(5'd14, 5'd15, 5'd16, 1'b0, 1'b0);

        rst = 1'b1;
        idle_in();
        cyc("rst_c0", O_RST);
        cyc("rst_c1", O_RST);
        rst = 1'b0;
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_slot0", {13'd0, dut.u_shadow.slot0}, 32'd0);
        cyc("rst_release", O_RUN);

        // Load directly ahead of its consumer: two bubbles.
        id_valid = 1'b1;
        id_rb = lw5;   cyc("d1_lw", O_RUN);
        id_rb = add5;  cyc("d1_bub1", O_BUB);
        cyc("d1_bub2", O_BUB);
        cyc("d1_go", O_RUN);
        check("d1_stall_cnt", stall_cnt, 32'd2);
        check("d1_slot0_add", {13'd0, dut.u_shadow.slot0}, {13'd0, add5});

        // One independent op in between: one bubble.
        id_rb = lw5;    cyc("d2_lw", O_RUN);
        id_rb = xor_op; cyc("d2_indep", O_RUN);
        id_rb = sub5;   cyc("d2_bub", O_BUB);
        cyc("d2_go", O_RUN);
        check("d2_stall_cnt", stall_cnt, 32'd3);

        // x0 is never a hazard.
        id_rb = lw0;  cyc("x0_lw", O_RUN);
        id_rb = use0; cyc("x0_use", O_RUN);

        // Memory wait: three held cycles, queue slot frozen.
        id_rb = mem_op;
        ex_mem_wait = 1'b1;
        cyc("mw_c0", O_MEM);
        cyc("mw_c1", O_MEM);
        cyc("mw_c2", O_MEM);
        check("mw_slot0_held", {13'd0, dut.u_shadow.slot0}, {13'd0, use0});
        ex_mem_wait = 1'b0;
        cyc("mw_run", O_RUN);
        check("mw_stall_cnt", stall_cnt, 32'd6);

        // Redirect: exactly two flush cycles, shadows emptied.
        idle_in();
        ex_redirect = 1'b1; cyc("rd_c0", O_FL);
        ex_redirect = 1'b0; cyc("rd_c1", O_FL);
        check("rd_slot0", {13'd0, dut.u_shadow.slot0}, 32'd0);
        check("rd_slot1", {13'd0, dut.u_shadow.slot1}, 32'd0);
        cyc("rd_c2", O_RUN);

        // Redirect aborts a memory wait; wait requests are ignored while flushing.
        ex_mem_wait = 1'b1; cyc("rm_wait", O_MEM);
        ex_redirect = 1'b1; cyc("rm_abort", O_FL);
        ex_redirect = 1'b0; cyc("rm_ignore_wait", O_FL);
        ex_mem_wait = 1'b0; cyc("rm_run", O_RUN);
        check("rm_stall_cnt", stall_cnt, 32'd7);

        // Redirect inside the flush window restarts it.
        ex_redirect = 1'b1; cyc("rr_c0", O_FL);
        cyc("rr_c1", O_FL);
        ex_redirect = 1'b0; cyc("rr_c2", O_FL);
        cyc("rr_c3", O_RUN);

        // Redirect, memory wait and load-use together: flush outputs only.
        id_valid = 1'b1;
        id_rb = lw5;  cyc("pr_lw", O_RUN);
        id_rb = add5; ex_mem_wait = 1'b1; ex_redirect = 1'b1;
        cyc("pr_all", O_FL);
        ex_mem_wait = 1'b0; ex_redirect = 1'b0;
        cyc("pr_flush", O_FL);
        cyc("pr_run", O_RUN);
        check("pr_stall_cnt", stall_cnt, 32'd7);

        // Reset during a memory wait.
        idle_in();
        ex_mem_wait = 1'b1; cyc("mr_wait", O_MEM);
        rst = 1'b1;         cyc("mr_rst", O_RST);
        rst = 1'b0; ex_mem_wait = 1'b0;
        check("mr_stall_cnt", stall_cnt, 32'd0);
        cyc("mr_run", O_RUN);

        // Reset during a flush window discards the remaining flush cycle.
        ex_redirect = 1'b1; cyc("fr_rd", O_FL);
        ex_redirect = 1'b0; rst = 1'b1; cyc("fr_rst", O_RST);
        rst = 1'b0;         cyc("fr_run", O_RUN);

        // 20 stall cycles: wide counter exact, 4-bit counter pinned at 15.
        rst = 1'b1; cyc("sat_rst", O_RST);
        rst = 1'b0; ex_mem_wait = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc("sat_wait", O_MEM);
            if (i == 14) begin
                check("sat_at15_wide", stall_cnt, 32'd15);
                check("sat_at15_narrow", {28'd0, stall_cnt_s}, 32'd15);
            end
        end
        ex_mem_wait = 1'b0;
        cyc("sat_end", O_RUN);
        check("sat_wide", stall_cnt, 32'd20);
        check("sat_narrow", {28'd0, stall_cnt_s}, 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
